// File: rtl/rv_alu_mdu.sv
// rv_alu_mdu: RV32I-style ALU with an optional iterative M-extension unit.
// The ALU result registers one cycle after accept. M ops run one
// radix-2 step per cycle (shift-add multiply, restoring divide), then a
// sign/half-select stage, so every M op takes XLEN+2 cycles no matter
// what the data is.
//
// Ports:
//   clk_in, rst_n_in         clock (rising edge), async active-low reset
//   flush_in                 synchronous abort of any in-flight op
//   valid_in / ready_out     request handshake (transfer on both high)
//   op_1_in, op_2_in         operands, sampled only at accept
//   opcode_in                [2:0] funct3, [3] alt (SUB/SRA, ALU only)
//   m_sel_in                 selects an M op (ignored when EN_M = 0)
//   valid_out / ready_in     result handshake (retire on both high)
//   result_out               registered result
module rv_alu_mdu #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [3:0]      opcode_in,
  input  logic            m_sel_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state;
  logic [2*XLEN-1:0]   acc;      // product, or {remainder, quotient/dividend}
  logic [XLEN-1:0]     opb;      // multiplicand or divisor magnitude
  logic [CW-1:0]       cnt;
  logic [2:0]          f3;
  logic                neg_res;  // product / quotient must be negated
  logic                neg_rem;  // remainder takes the dividend sign
  logic                div0;

  logic                m_sel;
  logic                accept;
  logic [SW-1:0]       shamt;
  logic [XLEN-1:0]     alu_res;
  logic                op1_signed, op2_signed, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   step_next;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;

  // With EN_M = 0 the select is constant 0 and the whole M path folds away.
  assign m_sel      = EN_M & m_sel_in;
  assign ready_out  = (state == IDLE) || (state == DONE && ready_in);
  assign valid_out  = (state == DONE);
  assign accept     = valid_in && ready_out && !flush_in;
  assign shamt      = op_2_in[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode_in[2:0])
      3'b000: alu_res = opcode_in[3] ? op_1_in - op_2_in : op_1_in + op_2_in;
      3'b001: alu_res = op_1_in << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, op_1_in < op_2_in};
      3'b100: alu_res = op_1_in ^ op_2_in;
      3'b101: alu_res = opcode_in[3] ? XLEN'($signed(op_1_in) >>> shamt)
                                     : op_1_in >> shamt;
      3'b110: alu_res = op_1_in | op_2_in;
      default: alu_res = op_1_in & op_2_in;
    endcase
  end

  // Operand signedness per M funct3: MULH, DIV, REM treat both operands as
  // signed; MULHSU only op1. Everything runs on magnitudes and the sign is
  // reapplied in FIX.
  always_comb begin
    op1_signed = (opcode_in[2:0] == 3'b001) || (opcode_in[2:0] == 3'b010) ||
                 (opcode_in[2:0] == 3'b100) || (opcode_in[2:0] == 3'b110);
    op2_signed = (opcode_in[2:0] == 3'b001) || (opcode_in[2:0] == 3'b100) ||
                 (opcode_in[2:0] == 3'b110);
    neg1 = op1_signed & op_1_in[XLEN-1];
    neg2 = op2_signed & op_2_in[XLEN-1];
    mag1 = neg1 ? -op_1_in : op_1_in;
    mag2 = neg2 ? -op_2_in : op_2_in;
  end

  // One iteration step. Multiply adds opb into the upper half when the
  // current multiplier bit is set, then shifts right. Divide shifts the next
  // dividend bit into the partial remainder and subtracts when it fits; the
  // remainder stays below the divisor, so no extra borrow bit is kept.
  // Dividing by zero naturally yields quotient all-ones, remainder=dividend.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    step_next = acc;
    if (f3[2]) begin
      if (div_shift >= {1'b0, opb})
        step_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        step_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      if (acc[0])
        step_next = {mul_sum, acc[XLEN-1:1]};
      else
        step_next = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  // Sign correction and result selection. MIN / -1 needs no special case:
  // the quotient magnitude 2^(XLEN-1) negates back to MIN and remainder is 0.
  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = div0 ? '1 : (neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
    rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (f3)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Control FSM and datapath registers. Flush only redirects the state, so
  // result_out keeps its last value while valid_out drops with DONE.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      result_out <= '0;
      acc        <= '0;
      opb        <= '0;
      cnt        <= '0;
      f3         <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      div0       <= 1'b0;
    end else if (flush_in) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (m_sel) begin
              acc     <= {{XLEN{1'b0}}, mag1};
              opb     <= mag2;
              cnt     <= CW'(XLEN);
              f3      <= opcode_in[2:0];
              neg_res <= neg1 ^ neg2;
              neg_rem <= neg1;
              div0    <= (op_2_in == '0);
              state   <= CALC;
            end else begin
              result_out <= alu_res;
              state      <= DONE;
            end
          end else if (state == DONE && ready_in) begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          result_out <= fix_res;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_mdu.sv
// tb_rv_alu_mdu: self-checking bench for rv_alu_mdu. A directed vector
// table, hand-written backpressure/flush/reset sequences, randomized ops
// against an arithmetic reference model, and a 16-bit instance for the
// width-generic ADD/DIV cases.
module tb_rv_alu_mdu;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic        msel;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [31:0] op_1 = '0;
  logic [31:0] op_2 = '0;
  logic [3:0]  opcode = '0;
  logic        m_sel = 1'b0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [31:0] result;

  logic        valid_in_16 = 1'b0;
  logic        ready_out_16;
  logic [15:0] op_1_16 = '0;
  logic [15:0] op_2_16 = '0;
  logic [3:0]  opcode_16 = '0;
  logic        m_sel_16 = 1'b0;
  logic        valid_out_16;
  logic [15:0] result_16;

  int compared = 0;
  int mismatched = 0;

  rv_alu_mdu #(.XLEN(32), .EN_M(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush_in),
    .valid_in(valid_in), .ready_out(ready_out),
    .op_1_in(op_1), .op_2_in(op_2), .opcode_in(opcode), .m_sel_in(m_sel),
    .valid_out(valid_out), .ready_in(ready_in), .result_out(result)
  );

  rv_alu_mdu #(.XLEN(16), .EN_M(1'b1)) dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(1'b0),
    .valid_in(valid_in_16), .ready_out(ready_out_16),
    .op_1_in(op_1_16), .op_2_in(op_2_16), .opcode_in(opcode_16),
    .m_sel_in(m_sel_16),
    .valid_out(valid_out_16), .ready_in(1'b1), .result_out(result_16)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the instruction semantics.
  function automatic logic [31:0] ref_model(input logic [31:0] a,
      input logic [31:0] b, input logic [3:0] opc, input logic msel);
    int          sa, sb;
    longint      pl;
    logic [63:0] pu;
    logic [4:0]  sh;
    sa = a;
    sb = b;
    sh = b[4:0];
    if (!msel) begin
      case (opc[2:0])
        3'd0: return opc[3] ? a - b : a + b;
        3'd1: return a << sh;
        3'd2: return (sa < sb) ? 32'd1 : 32'd0;
        3'd3: return (a < b) ? 32'd1 : 32'd0;
        3'd4: return a ^ b;
        3'd5: return opc[3] ? 32'(sa >>> sh) : a >> sh;
        3'd6: return a | b;
        default: return a & b;
      endcase
    end
    case (opc[2:0])
      3'd0: begin pu = 64'(a) * 64'(b); return pu[31:0]; end
      3'd1: begin pl = longint'(sa) * longint'(sb); return pl[63:32]; end
      3'd2: begin pl = longint'(sa) * longint'({32'b0, b}); return pl[63:32]; end
      3'd3: begin pu = 64'(a) * 64'(b); return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Drives a request and returns once it has been accepted; waits counts
  // the cycles spent waiting for ready_out.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] opc, input logic msel,
                                output int waits);
    op_1 = a; op_2 = b; opcode = opc; m_sel = msel; valid_in = 1'b1;
    waits = 0;
    while (!ready_out && waits < 200) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!ready_out) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: ready_out stayed 0 for %0d cycles, required 1", waits);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_result(output logic [31:0] res, output int lat,
                             output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!valid_out && lat < 200) begin
      if (ready_out) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic run16(input string name, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] opc,
                       input logic msel, input logic [15:0] exp);
    int lat;
    op_1_16 = a; op_2_16 = b; opcode_16 = opc; m_sel_16 = msel;
    valid_in_16 = 1'b1;
    @(posedge clk); #1;
    valid_in_16 = 1'b0;
    lat = 1;
    while (!valid_out_16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({name, "_res"}, {16'h0, result_16}, {16'h0, exp});
    check_output({name, "_lat"}, 32'(lat), msel ? 32'd18 : 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, a, b, exp;
    logic [3:0]  opc;
    logic        msel;
    int          waits, lat;
    bit          busy_ok, seen_valid;

    vecs.push_back('{"sub",        32'd5,        32'd7,        4'b1000, 1'b0, 32'hFFFFFFFE});
    vecs.push_back('{"sra",        32'h80000000, 32'd4,        4'b1101, 1'b0, 32'hF8000000});
    vecs.push_back('{"srl",        32'h80000000, 32'd4,        4'b0101, 1'b0, 32'h08000000});
    vecs.push_back('{"slt",        32'hFFFFFFFF, 32'd1,        4'b0010, 1'b0, 32'd1});
    vecs.push_back('{"sltu",       32'hFFFFFFFF, 32'd1,        4'b0011, 1'b0, 32'd0});
    vecs.push_back('{"add_wrap",   32'hFFFFFFFF, 32'd1,        4'b0000, 1'b0, 32'd0});
    vecs.push_back('{"sll31",      32'd1,        32'd31,       4'b0001, 1'b0, 32'h80000000});
    vecs.push_back('{"sll_amt32",  32'd1,        32'd32,       4'b0001, 1'b0, 32'd1});
    vecs.push_back('{"xor",        32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 1'b0, 32'h0FF00FF0});
    vecs.push_back('{"or",         32'hF0F0F0F0, 32'h0F000F00, 4'b0110, 1'b0, 32'hFFF0FFF0});
    vecs.push_back('{"and",        32'hF0F0F0F0, 32'hFF00FF00, 4'b0111, 1'b0, 32'hF000F000});
    vecs.push_back('{"mulhu",      32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0011, 1'b1, 32'hFFFFFFFE});
    vecs.push_back('{"mul",        32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 1'b1, 32'h00000001});
    vecs.push_back('{"mulh",       32'hFFFFFFF9, 32'd3,        4'b0001, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"mulhsu",     32'd2,        32'hFFFFFFFF, 4'b0010, 1'b1, 32'h00000001});
    vecs.push_back('{"div_ovf",    32'h80000000, 32'hFFFFFFFF, 4'b0100, 1'b1, 32'h80000000});
    vecs.push_back('{"rem_ovf",    32'h80000000, 32'hFFFFFFFF, 4'b0110, 1'b1, 32'd0});
    vecs.push_back('{"divu_by0",   32'd7,        32'd0,        4'b0101, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"remu_by0",   32'd7,        32'd0,        4'b0111, 1'b1, 32'd7});
    vecs.push_back('{"div_neg",    32'hFFFFFFF9, 32'd2,        4'b0100, 1'b1, 32'hFFFFFFFD});
    vecs.push_back('{"rem_neg",    32'hFFFFFFF9, 32'd2,        4'b0110, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"div_neg_by0",32'hFFFFFFF9, 32'd0,        4'b0100, 1'b1, 32'hFFFFFFFF});
    vecs.push_back('{"rem_neg_by0",32'hFFFFFFF9, 32'd0,        4'b0110, 1'b1, 32'hFFFFFFF9});
    vecs.push_back('{"div_alt_ign",32'd20,       32'd3,        4'b1100, 1'b1, 32'd6});

    // Reset values while rst_n is held low.
    #1;
    check_output("reset_valid", {31'b0, valid_out}, 32'd0);
    check_output("reset_ready", {31'b0, ready_out}, 32'd1);
    check_output("reset_result", result, 32'd0);
    check_output("reset_valid16", {31'b0, valid_out_16}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].opc, vecs[i].msel, waits);
      wait_result(res, lat, busy_ok);
      check_output({vecs[i].name, "_res"}, res, vecs[i].exp);
      check_output({vecs[i].name, "_lat"}, 32'(lat), vecs[i].msel ? 32'd34 : 32'd1);
      if (vecs[i].msel)
        check_output({vecs[i].name, "_busy"}, {31'b0, busy_ok}, 32'd1);
      if (i > 0)
        check_output({vecs[i].name, "_b2b"}, 32'(waits), 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] backpressure sequence");
    ready_in = 1'b0;
    apply_stimulus(32'd6, 32'd7, 4'b0000, 1'b1, waits);
    wait_result(res, lat, busy_ok);
    check_output("bp_res", res, 32'd42);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_output("bp_hold_valid", {31'b0, valid_out}, 32'd1);
      check_output("bp_hold_result", result, 32'd42);
      check_output("bp_hold_ready", {31'b0, ready_out}, 32'd0);
    end
    op_1 = 32'd10; op_2 = 32'd20; opcode = 4'b0000; m_sel = 1'b0;
    valid_in = 1'b1; ready_in = 1'b1;
    #1;
    check_output("bp_release_ready", {31'b0, ready_out}, 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check_output("bp_next_valid", {31'b0, valid_out}, 32'd1);
    check_output("bp_next_result", result, 32'd30);
    @(posedge clk); #1;

    $display("[TB] flush during divide");
    apply_stimulus(32'd1, 32'd2, 4'b0000, 1'b0, waits);
    wait_result(res, lat, busy_ok);
    check_output("pre_flush_add", res, 32'd3);
    apply_stimulus(32'd100, 32'd7, 4'b0100, 1'b1, waits);
    repeat (9) begin @(posedge clk); #1; end
    flush_in = 1'b1;
    op_1 = 32'd8; op_2 = 32'd9; opcode = 4'b0000; m_sel = 1'b0; valid_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0; valid_in = 1'b0;
    check_output("flush_valid", {31'b0, valid_out}, 32'd0);
    check_output("flush_idle_ready", {31'b0, ready_out}, 32'd1);
    check_output("flush_result_kept", result, 32'd3);
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) seen_valid = 1'b1;
    end
    check_output("flush_no_valid", {31'b0, seen_valid}, 32'd0);

    $display("[TB] reset during divide");
    apply_stimulus(32'hFFFFFF00, 32'd3, 4'b0100, 1'b1, waits);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_valid", {31'b0, valid_out}, 32'd0);
    check_output("midrst_ready", {31'b0, ready_out}, 32'd1);
    check_output("midrst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) seen_valid = 1'b1;
    end
    check_output("midrst_no_valid", {31'b0, seen_valid}, 32'd0);

    $display("[TB] randomized ops against reference model");
    for (int n = 0; n < 150; n++) begin
      a = rand_operand();
      b = rand_operand();
      opc = 4'($urandom_range(0, 15));
      msel = 1'($urandom_range(0, 1));
      exp = ref_model(a, b, opc, msel);
      apply_stimulus(a, b, opc, msel, waits);
      wait_result(res, lat, busy_ok);
      if (res !== exp)
        $display("[TB] random op %0d: a=0x%08h b=0x%08h opc=%0h m=%0b", n, a, b, opc, msel);
      check_output("rand_res", res, exp);
      check_output("rand_lat", 32'(lat), msel ? 32'd34 : 32'd1);
    end
    @(posedge clk); #1;

    $display("[TB] XLEN=16 instance");
    run16("x16_add",     16'h7FFF, 16'h0001, 4'b0000, 1'b0, 16'h8000);
    run16("x16_sub",     16'h0005, 16'h0007, 4'b1000, 1'b0, 16'hFFFE);
    run16("x16_sra",     16'h8000, 16'h0014, 4'b1101, 1'b0, 16'hF800);
    run16("x16_div_ovf", 16'h8000, 16'hFFFF, 4'b0100, 1'b1, 16'h8000);
    run16("x16_rem_ovf", 16'h8000, 16'hFFFF, 4'b0110, 1'b1, 16'h0000);
    run16("x16_div_neg", 16'hFFF9, 16'h0002, 4'b0100, 1'b1, 16'hFFFD);
    run16("x16_rem_neg", 16'hFFF9, 16'h0002, 4'b0110, 1'b1, 16'hFFFF);
    run16("x16_divu0",   16'h0007, 16'h0000, 4'b0101, 1'b1, 16'hFFFF);
    run16("x16_mulhu",   16'hFFFF, 16'hFFFF, 4'b0011, 1'b1, 16'hFFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
